// File: rtl/core_regfile.sv
// Architectural register store: GPR file with two bypassed combinational read ports,
// plus the SR/EPC/ESR special registers and their exception entry/return sequencing.
module core_regfile #(
    parameter int unsigned    NREGS    = 32,
    parameter int unsigned    DW       = 32,
    parameter logic [DW-1:0]  SR_RESET = DW'(32'h0000_0002),
    parameter int unsigned    SPR_SR   = 0,
    parameter int unsigned    SPR_EPC  = 1,
    parameter int unsigned    SPR_ESR  = 2,
    localparam int unsigned   AW       = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wb_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [DW-1:0] wb_data_i,
    input  logic [AW-1:0] rd_addr_a_i,
    input  logic [AW-1:0] rd_addr_b_i,
    output logic [DW-1:0] rd_data_a_o,
    output logic [DW-1:0] rd_data_b_o,
    input  logic          spr_we_i,
    input  logic [AW-1:0] spr_addr_i,
    input  logic [DW-1:0] spr_wdata_i,
    input  logic          exc_req_i,
    input  logic [DW-1:0] exc_pc_i,
    input  logic          rfe_i,
    output logic [DW-1:0] sr_o,
    output logic [DW-1:0] esr_o,
    output logic [DW-1:0] epc_o,
    output logic          in_exc_o
);

    localparam int unsigned IE_BIT  = 0;
    localparam int unsigned SUP_BIT = 1;

    logic [DW-1:0] gpr_q [NREGS];
    logic [DW-1:0] sr_q, sr_d;
    logic [DW-1:0] esr_q, esr_d;
    logic [DW-1:0] epc_q, epc_d;
    logic          in_exc_q, in_exc_d;

    // R0 is never written, so its storage stays at the reset value of zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (wb_i && (wb_addr_i != '0)) begin
            gpr_q[wb_addr_i] <= wb_data_i;
        end
    end

    assign rd_data_a_o = (rd_addr_a_i == '0) ? '0 :
                         (wb_i && (wb_addr_i == rd_addr_a_i)) ? wb_data_i :
                         gpr_q[rd_addr_a_i];

    assign rd_data_b_o = (rd_addr_b_i == '0) ? '0 :
                         (wb_i && (wb_addr_i == rd_addr_b_i)) ? wb_data_i :
                         gpr_q[rd_addr_b_i];

    // Exception entry outranks return-from-exception, which outranks move-to-SPR.
    always_comb begin
        sr_d     = sr_q;
        esr_d    = esr_q;
        epc_d    = epc_q;
        in_exc_d = in_exc_q;
        if (exc_req_i) begin
            epc_d           = exc_pc_i;
            esr_d           = sr_q;
            in_exc_d        = 1'b1;
            sr_d[IE_BIT]    = 1'b0;
            sr_d[SUP_BIT]   = 1'b1;
        end else if (rfe_i) begin
            sr_d     = esr_q;
            in_exc_d = 1'b0;
        end else if (spr_we_i) begin
            if (spr_addr_i == AW'(SPR_SR)) begin
                sr_d = spr_wdata_i;
            end else if (spr_addr_i == AW'(SPR_EPC)) begin
                epc_d = spr_wdata_i;
            end else if (spr_addr_i == AW'(SPR_ESR)) begin
                esr_d = spr_wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q     <= SR_RESET;
            esr_q    <= '0;
            epc_q    <= '0;
            in_exc_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            esr_q    <= esr_d;
            epc_q    <= epc_d;
            in_exc_q <= in_exc_d;
        end
    end

    assign sr_o     = sr_q;
    assign esr_o    = esr_q;
    assign epc_o    = epc_q;
    assign in_exc_o = in_exc_q;

endmodule

// File: tb/tb_core_regfile.sv
// Bench for core_regfile: reset sweep, directed vector table, randomized traffic
// against a behavioural model, and an asynchronous mid-cycle reset sequence.
module tb_core_regfile;

    typedef struct {
        logic        wb;
        logic [4:0]  wbAddr;
        logic [31:0] wbData;
        logic [4:0]  rdA;
        logic [4:0]  rdB;
        logic        sprWe;
        logic [4:0]  sprAddr;
        logic [31:0] sprWdata;
        logic        exc;
        logic [31:0] excPc;
        logic        rfe;
        logic [31:0] expA;
        logic [31:0] expB;
        logic [31:0] expSr;
        logic [31:0] expEsr;
        logic [31:0] expEpc;
        logic        expInExc;
    } vec_t;

    logic        clk;
    logic        rst_ni;
    logic        wb;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic [4:0]  rdAddrA;
    logic [4:0]  rdAddrB;
    logic [31:0] rdDataA;
    logic [31:0] rdDataB;
    logic        sprWe;
    logic [4:0]  sprAddr;
    logic [31:0] sprWdata;
    logic        excReq;
    logic [31:0] excPc;
    logic        rfe;
    logic [31:0] sr;
    logic [31:0] esr;
    logic [31:0] epc;
    logic        inExc;

    int numChecks = 0;
    int numErrors = 0;

    logic [31:0] mGpr [32];
    logic [31:0] mSr;
    logic [31:0] mEsr;
    logic [31:0] mEpc;
    logic        mInExc;

    vec_t vecs [21];

    core_regfile dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .wb_i        (wb),
        .wb_addr_i   (wbAddr),
        .wb_data_i   (wbData),
        .rd_addr_a_i (rdAddrA),
        .rd_addr_b_i (rdAddrB),
        .rd_data_a_o (rdDataA),
        .rd_data_b_o (rdDataB),
        .spr_we_i    (sprWe),
        .spr_addr_i  (sprAddr),
        .spr_wdata_i (sprWdata),
        .exc_req_i   (excReq),
        .exc_pc_i    (excPc),
        .rfe_i       (rfe),
        .sr_o        (sr),
        .esr_o       (esr),
        .epc_o       (epc),
        .in_exc_o    (inExc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: architectural state after each edge, straight from the rules.
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) mGpr[i] <= 32'h0;
            mSr    <= 32'h2;
            mEsr   <= 32'h0;
            mEpc   <= 32'h0;
            mInExc <= 1'b0;
        end else begin
            if (wb && wbAddr != 5'd0) mGpr[wbAddr] <= wbData;
            if (excReq) begin
                mEpc   <= excPc;
                mEsr   <= mSr;
                mInExc <= 1'b1;
                mSr    <= (mSr & ~32'h1) | 32'h2;
            end else if (rfe) begin
                mSr    <= mEsr;
                mInExc <= 1'b0;
            end else if (sprWe) begin
                if (sprAddr == 5'd0) mSr <= sprWdata;
                else if (sprAddr == 5'd1) mEpc <= sprWdata;
                else if (sprAddr == 5'd2) mEsr <= sprWdata;
            end
        end
    end

    function automatic logic [31:0] expRead(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
        if (wb && wbAddr == addr) return wbData;
        return mGpr[addr];
    endfunction

    function automatic vec_t mkVec(
        input logic w, input logic [4:0] wa, input logic [31:0] wd,
        input logic [4:0] ra, input logic [4:0] rb,
        input logic sw, input logic [4:0] sa, input logic [31:0] sd,
        input logic ex, input logic [31:0] pc, input logic rf,
        input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] es,
        input logic [31:0] ee, input logic [31:0] ep, input logic ei);
        vec_t v;
        v.wb = w; v.wbAddr = wa; v.wbData = wd; v.rdA = ra; v.rdB = rb;
        v.sprWe = sw; v.sprAddr = sa; v.sprWdata = sd;
        v.exc = ex; v.excPc = pc; v.rfe = rf;
        v.expA = ea; v.expB = eb; v.expSr = es; v.expEsr = ee; v.expEpc = ep; v.expInExc = ei;
        return v;
    endfunction

    task automatic clearInputs();
        wb = 0; wbAddr = 0; wbData = 0; rdAddrA = 0; rdAddrB = 0;
        sprWe = 0; sprAddr = 0; sprWdata = 0; excReq = 0; excPc = 0; rfe = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        wb = v.wb; wbAddr = v.wbAddr; wbData = v.wbData;
        rdAddrA = v.rdA; rdAddrB = v.rdB;
        sprWe = v.sprWe; sprAddr = v.sprAddr; sprWdata = v.sprWdata;
        excReq = v.exc; excPc = v.excPc; rfe = v.rfe;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkSpr(input string tag, input logic [31:0] s, input logic [31:0] e,
                            input logic [31:0] p, input logic ie);
        checkOutput({tag, " sr"}, sr, s);
        checkOutput({tag, " esr"}, esr, e);
        checkOutput({tag, " epc"}, epc, p);
        checkOutput({tag, " in_exc"}, {31'b0, inExc}, {31'b0, ie});
    endtask

    initial begin
        vecs[0]  = mkVec(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0,           0, 0, 0, 32'hDEADBEEF, 0,  32'h2, 0, 0, 0);
        vecs[1]  = mkVec(1, 0, 32'h1234,     5, 0, 0, 0, 0,           0, 0, 0, 32'hDEADBEEF, 0,  32'h2, 0, 0, 0);
        vecs[2]  = mkVec(0, 0, 0,            5, 0, 1, 0, 32'h1,       0, 0, 0, 32'hDEADBEEF, 0,  32'h2, 0, 0, 0);
        vecs[3]  = mkVec(1, 7, 32'h77,       5, 7, 0, 0, 0,           1, 32'h100, 0, 32'hDEADBEEF, 32'h77, 32'h1, 0, 0, 0);
        vecs[4]  = mkVec(0, 0, 0,            5, 7, 0, 0, 0,           0, 0, 0, 32'hDEADBEEF, 32'h77, 32'h2, 32'h1, 32'h100, 1);
        vecs[5]  = mkVec(0, 0, 0,            5, 7, 0, 0, 0,           0, 0, 1, 32'hDEADBEEF, 32'h77, 32'h2, 32'h1, 32'h100, 1);
        vecs[6]  = mkVec(0, 0, 0,            5, 7, 0, 0, 0,           0, 0, 0, 32'hDEADBEEF, 32'h77, 32'h1, 32'h1, 32'h100, 0);
        vecs[7]  = mkVec(0, 0, 0,            5, 7, 1, 1, 32'h55,      1, 32'h200, 1, 32'hDEADBEEF, 32'h77, 32'h1, 32'h1, 32'h100, 0);
        vecs[8]  = mkVec(0, 0, 0,            5, 7, 0, 0, 0,           0, 0, 0, 32'hDEADBEEF, 32'h77, 32'h2, 32'h1, 32'h200, 1);
        vecs[9]  = mkVec(0, 0, 0,            5, 7, 1, 7, 32'hFFFF,    0, 0, 0, 32'hDEADBEEF, 32'h77, 32'h2, 32'h1, 32'h200, 1);
        vecs[10] = mkVec(0, 0, 0,            5, 7, 0, 0, 0,           0, 0, 0, 32'hDEADBEEF, 32'h77, 32'h2, 32'h1, 32'h200, 1);
        vecs[11] = mkVec(0, 0, 0,            5, 7, 1, 2, 32'hF0F0F0F1, 0, 0, 0, 32'hDEADBEEF, 32'h77, 32'h2, 32'h1, 32'h200, 1);
        vecs[12] = mkVec(0, 0, 0,            5, 7, 0, 0, 0,           0, 0, 0, 32'hDEADBEEF, 32'h77, 32'h2, 32'hF0F0F0F1, 32'h200, 1);
        vecs[13] = mkVec(0, 0, 0,            5, 7, 0, 0, 0,           1, 32'h300, 0, 32'hDEADBEEF, 32'h77, 32'h2, 32'hF0F0F0F1, 32'h200, 1);
        vecs[14] = mkVec(0, 0, 0,            5, 7, 1, 0, 32'hABCD0001, 0, 0, 0, 32'hDEADBEEF, 32'h77, 32'h2, 32'h2, 32'h300, 1);
        vecs[15] = mkVec(0, 0, 0,            5, 7, 0, 0, 0,           1, 32'h400, 0, 32'hDEADBEEF, 32'h77, 32'hABCD0001, 32'h2, 32'h300, 1);
        vecs[16] = mkVec(0, 0, 0,            5, 7, 0, 0, 0,           0, 0, 0, 32'hDEADBEEF, 32'h77, 32'hABCD0002, 32'hABCD0001, 32'h400, 1);
        vecs[17] = mkVec(0, 0, 0,            5, 7, 0, 0, 0,           0, 0, 1, 32'hDEADBEEF, 32'h77, 32'hABCD0002, 32'hABCD0001, 32'h400, 1);
        vecs[18] = mkVec(0, 0, 0,            5, 7, 1, 2, 32'h5,       0, 0, 0, 32'hDEADBEEF, 32'h77, 32'hABCD0001, 32'hABCD0001, 32'h400, 0);
        vecs[19] = mkVec(0, 0, 0,            5, 7, 0, 0, 0,           0, 0, 1, 32'hDEADBEEF, 32'h77, 32'hABCD0001, 32'h5, 32'h400, 0);
        vecs[20] = mkVec(0, 0, 0,            5, 7, 0, 0, 0,           0, 0, 0, 32'hDEADBEEF, 32'h77, 32'h5, 32'h5, 32'h400, 0);

        clearInputs();
        rst_ni = 1'b1;
        #2 rst_ni = 1'b0;
        @(negedge clk);

        // Reset state: every index reads zero on both ports, SPRs at their reset values.
        for (int i = 0; i < 32; i++) begin
            rdAddrA = 5'(i);
            rdAddrB = 5'(31 - i);
            #1;
            checkOutput($sformatf("reset rdA[%0d]", i), rdDataA, 32'h0);
            checkOutput($sformatf("reset rdB[%0d]", 31 - i), rdDataB, 32'h0);
        end
        checkSpr("reset", 32'h2, 32'h0, 32'h0, 1'b0);

        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d rdA", i), rdDataA, vecs[i].expA);
            checkOutput($sformatf("row%0d rdB", i), rdDataB, vecs[i].expB);
            checkSpr($sformatf("row%0d", i), vecs[i].expSr, vecs[i].expEsr, vecs[i].expEpc, vecs[i].expInExc);
            @(negedge clk);
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            wb       = ($urandom_range(0, 3) != 0);
            wbAddr   = 5'($urandom_range(0, 31));
            wbData   = $urandom;
            rdAddrA  = ($urandom_range(0, 3) == 0) ? wbAddr : 5'($urandom_range(0, 31));
            rdAddrB  = ($urandom_range(0, 3) == 0) ? wbAddr : 5'($urandom_range(0, 31));
            sprWe    = ($urandom_range(0, 3) == 0);
            sprAddr  = 5'($urandom_range(0, 7));
            sprWdata = $urandom;
            excReq   = ($urandom_range(0, 9) == 0);
            excPc    = $urandom;
            rfe      = ($urandom_range(0, 7) == 0);
            #1;
            checkOutput($sformatf("rand%0d rdA", n), rdDataA, expRead(rdAddrA));
            checkOutput($sformatf("rand%0d rdB", n), rdDataB, expRead(rdAddrB));
            checkSpr($sformatf("rand%0d", n), mSr, mEsr, mEpc, mInExc);
            @(negedge clk);
        end

        // Asynchronous reset between edges, strobes held during reset are discarded.
        clearInputs();
        wb = 1; wbAddr = 5'd3; wbData = 32'hA5;
        sprWe = 1; sprAddr = 5'd0; sprWdata = 32'h1;
        @(negedge clk);
        clearInputs();
        rdAddrA = 5'd3;
        #1;
        checkOutput("pre-reset R3", rdDataA, 32'hA5);
        checkOutput("pre-reset sr", sr, 32'h1);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("async reset R3", rdDataA, 32'h0);
        checkSpr("async reset", 32'h2, 32'h0, 32'h0, 1'b0);
        excReq = 1; excPc = 32'h999;
        sprWe = 1; sprAddr = 5'd0; sprWdata = 32'hF;
        wb = 1; wbAddr = 5'd3; wbData = 32'h99;
        @(posedge clk);
        #1;
        clearInputs();
        rdAddrA = 5'd3;
        #1;
        checkOutput("held reset R3", rdDataA, 32'h0);
        checkSpr("held reset", 32'h2, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        checkOutput("post-reset R3", rdDataA, 32'h0);
        checkSpr("post-reset", 32'h2, 32'h0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
